// File: rtl/risc_ctrl_fsm_if.sv
// Memory handshake bundle between the control sequencer
// and the shared instruction/data memory.
interface risc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit RISC datapath:
// fetch, decode, execute, memory and writeback with ack timeout.
module risc_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  risc_ctrl_fsm_if.master mem,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       rf_we,
  output logic       wb_sel,
  output logic [1:0] alu_op,
  output logic       led_we,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } st_t;

  st_t              r_state;
  st_t              w_next;
  logic [CNT_W-1:0] r_cnt;

  logic w_is_alu;
  logic w_is_ld;
  logic w_is_st;
  logic w_is_exe;
  logic w_is_ctl;
  logic w_is_hlt;
  logic w_req;
  logic w_ack;
  logic w_tmo;

  assign w_is_alu = (opcode >= 4'd1) && (opcode <= 4'd4);
  assign w_is_ld  = (opcode == 4'd5);
  assign w_is_st  = (opcode == 4'd6);
  assign w_is_exe = w_is_alu || w_is_ld || w_is_st;
  assign w_is_ctl = (opcode == 4'd0) || (opcode == 4'd7) ||
                    (opcode == 4'd8) || (opcode == 4'd9);
  assign w_is_hlt = (opcode == 4'hF);

  // A nonzero count means the fetch request is already out,
  // so run only gates the first FETCH cycle.
  assign w_req = ((r_state == S_FETCH) && (run || (r_cnt != '0))) ||
                 (r_state == S_MEM);
  assign w_ack = w_req && mem.mem_ack;
  assign w_tmo = w_req && !mem.mem_ack &&
                 (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!w_req)     w_next = S_IDLE;
        else if (w_ack) w_next = S_DECODE;
        else if (w_tmo) w_next = S_FAULT;
      end
      S_DECODE: begin
        unique case (1'b1)
          w_is_exe: w_next = S_EXEC;
          w_is_ctl: w_next = S_FETCH;
          w_is_hlt: w_next = S_HALT;
          default:  w_next = S_FAULT;
        endcase
      end
      S_EXEC: begin
        w_next = (w_is_ld || w_is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (w_ack)      w_next = w_is_st ? S_FETCH : S_WB;
        else if (w_tmo) w_next = S_FAULT;
      end
      S_WB: begin
        w_next = S_FETCH;
      end
      default: begin
        w_next = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_req && !mem.mem_ack && (w_next == r_state))
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
    end
  end

  always_comb begin
    mem.mem_req  = w_req;
    mem.mem_we   = (r_state == S_MEM) && w_is_st;
    mem.addr_sel = (r_state == S_MEM);
    ir_we        = (r_state == S_FETCH) && w_ack;
    pc_inc       = (r_state == S_FETCH) && w_ack;
    pc_load      = (r_state == S_DECODE) &&
                   ((opcode == 4'd8) || ((opcode == 4'd7) && zero));
    led_we       = (r_state == S_DECODE) && (opcode == 4'd9);
    alu_op       = 2'b00;
    if ((r_state == S_EXEC) && w_is_alu)
      alu_op = 2'(opcode - 4'd1);
    rf_we        = (r_state == S_WB);
    wb_sel       = (r_state == S_WB) && w_is_ld;
    halted       = (r_state == S_HALT);
    fault        = (r_state == S_FAULT);
    state        = r_state;
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Scoreboard bench for risc_ctrl_fsm: per-cycle expected
// state/output vectors queued at drive time, checked at sample.
module tb_risc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero;
  logic       ir_we;
  logic       pc_inc;
  logic       pc_load;
  logic       rf_we;
  logic       wb_sel;
  logic [1:0] alu_op;
  logic       led_we;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  risc_ctrl_fsm_if m ();

  risc_ctrl_fsm #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem     (m.master),
    .run     (run),
    .opcode  (opcode),
    .zero    (zero),
    .ir_we   (ir_we),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .rf_we   (rf_we),
    .wb_sel  (wb_sel),
    .alu_op  (alu_op),
    .led_we  (led_we),
    .halted  (halted),
    .fault   (fault),
    .state   (state)
  );

  localparam logic [12:0] NON = 13'h0000;
  localparam logic [12:0] REQ = 13'h1000;
  localparam logic [12:0] WE  = 13'h0800;
  localparam logic [12:0] AS  = 13'h0400;
  localparam logic [12:0] IRW = 13'h0200;
  localparam logic [12:0] PCI = 13'h0100;
  localparam logic [12:0] PCL = 13'h0080;
  localparam logic [12:0] RFW = 13'h0040;
  localparam logic [12:0] WBS = 13'h0020;
  localparam logic [12:0] LED = 13'h0004;
  localparam logic [12:0] HLT = 13'h0002;
  localparam logic [12:0] FLT = 13'h0001;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } sb_t;

  sb_t sb[$];
  int  n_tests;
  int  n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] e(input logic [2:0] s,
                                    input logic [12:0] o);
    return {s, o};
  endfunction

  function automatic logic [15:0] obs();
    return {state, m.mem_req, m.mem_we, m.addr_sel, ir_we, pc_inc,
            pc_load, rf_we, wb_sel, alu_op, led_we, halted, fault};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [15:0] ex);
    sb_t it;
    sb.push_back('{tag, ex});
    it = sb.pop_front();
    chk(it.tag, obs(), it.v);
  endtask

  // Called at a negedge: drive ack, sample mid-low-phase, then step.
  task automatic cyc(input logic ack, input string tag,
                     input logic [15:0] ex);
    sb_t it;
    m.mem_ack = ack;
    sb.push_back('{tag, ex});
    #2;
    it = sb.pop_front();
    chk(it.tag, obs(), it.v);
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst_n     = 1'b0;
    run       = 1'b0;
    zero      = 1'b0;
    m.mem_ack = 1'b0;
    cyc(1'b0, "rst", e(3'd0, NON));
    rst_n = 1'b1;
  endtask

  // Reset, run from IDLE, and complete a zero-wait fetch.
  task automatic to_decode(input logic [3:0] op);
    do_rst();
    run    = 1'b1;
    opcode = op;
    cyc(1'b0, "idle", e(3'd0, NON));
    cyc(1'b1, "fetch_ack", e(3'd1, REQ | IRW | PCI));
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    run       = 1'b0;
    opcode    = 4'd0;
    zero      = 1'b0;
    m.mem_ack = 1'b0;

    // ALU add, full path
    to_decode(4'd1);
    cyc(1'b0, "add_dec", e(3'd2, NON));
    cyc(1'b0, "add_exec", e(3'd3, NON));
    cyc(1'b0, "add_wb", e(3'd5, RFW));
    cyc(1'b0, "add_fetch2", e(3'd1, REQ));

    // alu_op for SUB/AND/OR
    for (int op = 2; op <= 4; op++) begin
      to_decode(4'(op));
      cyc(1'b0, "alu_dec", e(3'd2, NON));
      cyc(1'b0, "alu_exec", e(3'd3, 13'((op - 1) << 3)));
      cyc(1'b0, "alu_wb", e(3'd5, RFW));
    end

    // LD with 3-cycle memory wait
    to_decode(4'd5);
    cyc(1'b0, "ld_dec", e(3'd2, NON));
    cyc(1'b0, "ld_exec", e(3'd3, NON));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, "ld_mem_wait", e(3'd4, REQ | AS));
    cyc(1'b1, "ld_mem_ack", e(3'd4, REQ | AS));
    cyc(1'b0, "ld_wb", e(3'd5, RFW | WBS));
    cyc(1'b0, "ld_fetch2", e(3'd1, REQ));

    // ST
    to_decode(4'd6);
    cyc(1'b0, "st_dec", e(3'd2, NON));
    cyc(1'b0, "st_exec", e(3'd3, NON));
    cyc(1'b1, "st_mem_ack", e(3'd4, REQ | WE | AS));
    cyc(1'b0, "st_fetch2", e(3'd1, REQ));

    // BEQZ taken / not taken, JMP
    to_decode(4'd7);
    zero = 1'b1;
    cyc(1'b0, "beqz_z1_dec", e(3'd2, PCL));
    cyc(1'b0, "beqz_z1_fetch", e(3'd1, REQ));
    to_decode(4'd7);
    zero = 1'b0;
    cyc(1'b0, "beqz_z0_dec", e(3'd2, NON));
    cyc(1'b0, "beqz_z0_fetch", e(3'd1, REQ));
    to_decode(4'd8);
    cyc(1'b0, "jmp_dec", e(3'd2, PCL));
    cyc(1'b0, "jmp_fetch", e(3'd1, REQ));

    // OUT, NOP, illegal
    to_decode(4'd9);
    cyc(1'b0, "out_dec", e(3'd2, LED));
    cyc(1'b0, "out_fetch", e(3'd1, REQ));
    to_decode(4'd0);
    cyc(1'b0, "nop_dec", e(3'd2, NON));
    cyc(1'b0, "nop_fetch", e(3'd1, REQ));
    to_decode(4'hC);
    cyc(1'b0, "ill_dec", e(3'd2, NON));
    cyc(1'b0, "ill_fault", e(3'd7, FLT));
    cyc(1'b0, "ill_fault2", e(3'd7, FLT));

    // run=0 on entering FETCH returns to IDLE without a request
    do_rst();
    run = 1'b1;
    cyc(1'b0, "norun_idle", e(3'd0, NON));
    run = 1'b0;
    cyc(1'b0, "norun_fetch", e(3'd1, NON));
    cyc(1'b0, "norun_back", e(3'd0, NON));

    // fetch timeout: 15 request cycles then sticky FAULT
    do_rst();
    run = 1'b1;
    cyc(1'b0, "tmo_idle", e(3'd0, NON));
    for (int i = 0; i < 15; i++)
      cyc(1'b0, "tmo_fetch", e(3'd1, REQ));
    cyc(1'b1, "tmo_fault_lateack", e(3'd7, FLT));
    run = 1'b0;
    cyc(1'b0, "tmo_fault_hold", e(3'd7, FLT));

    // ack on the 15th cycle wins; run dropped mid-request ignored
    do_rst();
    run    = 1'b1;
    opcode = 4'd0;
    cyc(1'b0, "ack15_idle", e(3'd0, NON));
    cyc(1'b0, "ack15_fetch1", e(3'd1, REQ));
    run = 1'b0;
    for (int i = 0; i < 13; i++)
      cyc(1'b0, "ack15_fetch", e(3'd1, REQ));
    cyc(1'b1, "ack15_ack", e(3'd1, REQ | IRW | PCI));
    cyc(1'b0, "ack15_dec", e(3'd2, NON));

    // HALT holds through run toggling
    to_decode(4'hF);
    cyc(1'b0, "hlt_dec", e(3'd2, NON));
    cyc(1'b0, "hlt_1", e(3'd6, HLT));
    run = 1'b0;
    cyc(1'b1, "hlt_2", e(3'd6, HLT));
    run = 1'b1;
    cyc(1'b0, "hlt_3", e(3'd6, HLT));

    // async reset mid-FETCH, observed before the next rising edge
    do_rst();
    run = 1'b1;
    cyc(1'b0, "arst_idle", e(3'd0, NON));
    m.mem_ack = 1'b0;
    #2;
    sb_chk("arst_fetch", e(3'd1, REQ));
    rst_n = 1'b0;
    #1;
    sb_chk("arst_async", e(3'd0, NON));
    @(negedge clk);
    sb_chk("arst_held", e(3'd0, NON));
    rst_n = 1'b1;
    run   = 1'b0;
    cyc(1'b0, "arst_after", e(3'd0, NON));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
